// File: rtl/glm_dot_pack.sv
// rtl/glm_dot_pack.sv - packs 32-bit dot results into 512-bit lines for the output FIFO or result BRAM
// Optional macro GLM_DOT_PACK_ZEROFILL_EN: clear the line register after each written line.
module glm_dot_pack #(
    parameter int VALUES_PER_LINE      = 16,
    parameter int LOG2_VALUES_PER_LINE = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            op_start,
    output logic                            op_done,
    input  logic [4:0][31:0]                regs,
    output logic                            FIFO_dot_re,
    input  logic                            FIFO_dot_rvalid,
    input  logic [31:0]                     FIFO_dot_rdata,
    input  logic                            FIFO_dot_empty,
    output logic                            FIFO_output_we,
    output logic [32*VALUES_PER_LINE-1:0]   FIFO_output_wdata,
    input  logic                            FIFO_output_almostfull,
    output logic                            MEM_result_we,
    output logic [15:0]                     MEM_result_waddr,
    output logic [32*VALUES_PER_LINE-1:0]   MEM_result_wdata
);
    localparam int LINE_W = 32 * VALUES_PER_LINE;
    localparam logic [LOG2_VALUES_PER_LINE-1:0] LAST_LANE = LOG2_VALUES_PER_LINE'(VALUES_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;
    state_t state, state_next;

    logic [15:0]                     num_values;
    logic                            write_to_mem;
    logic [15:0]                     mem_store_offset;
    logic [15:0]                     requested;
    logic [15:0]                     received;
    logic [15:0]                     lines_written;
    logic [LOG2_VALUES_PER_LINE-1:0] lane;
    logic [LINE_W-1:0]               line;
    logic [LINE_W-1:0]               line_out;
    logic [LINE_W-1:0]               line_ins;
    logic                            issue;
    logic                            take;
    logic                            last_val;
    logic                            line_done;

    wire [15:0] nv_in = regs[3][15:0];
    wire unused_regs = ^{regs[0], regs[1], regs[2], regs[3][31:17], regs[4][31:16]};

    always_comb begin
        issue     = (state == PACK) && !FIFO_dot_empty && (requested < num_values)
                    && (write_to_mem || !FIFO_output_almostfull);
        take      = (state == PACK) && FIFO_dot_rvalid;
        last_val  = (received == num_values - 16'd1);
        line_done = take && ((lane == LAST_LANE) || last_val);
        line_ins  = line;
        line_ins[32*lane +: 32] = FIFO_dot_rdata;
    end

    // Gated by reset so nothing is popped from the FIFO while the block is being cleared.
    assign FIFO_dot_re       = issue && !reset;
    assign FIFO_output_wdata = line_out;
    assign MEM_result_wdata  = line_out;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (op_start && (nv_in != 16'd0)) state_next = PACK;
            PACK:    if (take && last_val) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_done          <= 1'b0;
            FIFO_output_we   <= 1'b0;
            MEM_result_we    <= 1'b0;
            MEM_result_waddr <= '0;
            num_values       <= '0;
            write_to_mem     <= 1'b0;
            mem_store_offset <= '0;
            requested        <= '0;
            received         <= '0;
            lines_written    <= '0;
            lane             <= '0;
            line             <= '0;
            line_out         <= '0;
        end else begin
            op_done        <= 1'b0;
            FIFO_output_we <= 1'b0;
            MEM_result_we  <= 1'b0;

            if (state == IDLE && op_start) begin
                num_values       <= nv_in;
                write_to_mem     <= regs[3][16];
                mem_store_offset <= regs[4][15:0];
                requested        <= '0;
                received         <= '0;
                lines_written    <= '0;
                lane             <= '0;
                line             <= '0;
                if (nv_in == 16'd0) op_done <= 1'b1;
            end

            if (state == DONE) op_done <= 1'b1;

            if (issue) requested <= requested + 16'd1;

            if (take) begin
                received <= received + 16'd1;
                if (line_done) begin
                    // Snapshot into line_out so the next lane-0 value can land in line immediately.
                    lane     <= '0;
                    line_out <= line_ins;
`ifdef GLM_DOT_PACK_ZEROFILL_EN
                    line     <= '0;
`else
                    line     <= line_ins;
`endif
                    if (write_to_mem) begin
                        MEM_result_we    <= 1'b1;
                        MEM_result_waddr <= mem_store_offset + lines_written;
                        lines_written    <= lines_written + 16'd1;
                    end else begin
                        FIFO_output_we   <= 1'b1;
                    end
                end else begin
                    lane <= lane + 1'b1;
                    line <= line_ins;
                end
            end
        end
    end
endmodule

// File: tb/tb_glm_dot_pack.sv
// tb/tb_glm_dot_pack.sv - scoreboard bench for glm_dot_pack
module tb_glm_dot_pack;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             op_start = 1'b0;
    logic             op_done;
    logic [4:0][31:0] regs = '0;
    logic             FIFO_dot_re;
    logic             FIFO_dot_rvalid = 1'b0;
    logic [31:0]      FIFO_dot_rdata = '0;
    logic             FIFO_dot_empty;
    logic             FIFO_output_we;
    logic [511:0]     FIFO_output_wdata;
    logic             FIFO_output_almostfull = 1'b0;
    logic             MEM_result_we;
    logic [15:0]      MEM_result_waddr;
    logic [511:0]     MEM_result_wdata;

    always #5 clk = ~clk;

    glm_dot_pack dut (
        .clk(clk), .reset(reset), .op_start(op_start), .op_done(op_done), .regs(regs),
        .FIFO_dot_re(FIFO_dot_re), .FIFO_dot_rvalid(FIFO_dot_rvalid),
        .FIFO_dot_rdata(FIFO_dot_rdata), .FIFO_dot_empty(FIFO_dot_empty),
        .FIFO_output_we(FIFO_output_we), .FIFO_output_wdata(FIFO_output_wdata),
        .FIFO_output_almostfull(FIFO_output_almostfull),
        .MEM_result_we(MEM_result_we), .MEM_result_waddr(MEM_result_waddr),
        .MEM_result_wdata(MEM_result_wdata)
    );

    typedef struct {
        bit           is_mem;
        logic [15:0]  addr;
        logic [511:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_rv = 0;
    int          re_cnt = 0;
    int          re_viol = 0;
    int          done_cnt = 0;
    bit          cur_wtm = 1'b0;
    bit          toggle_en = 1'b0;
    bit          empty_mask = 1'b0;
    logic [31:0] fifo_mem [0:255];
    logic [7:0]  wp = '0;
    logic [7:0]  rp = '0;

`ifdef GLM_DOT_PACK_ZEROFILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    assign FIFO_dot_empty = (wp == rp) || empty_mask;

    // FIFO_dot model: data one cycle after re
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (FIFO_dot_re) begin
            FIFO_dot_rdata  <= fifo_mem[rp];
            rp              <= rp + 8'd1;
            FIFO_dot_rvalid <= 1'b1;
        end else begin
            FIFO_dot_rvalid <= 1'b0;
        end
        empty_mask <= toggle_en ? ~empty_mask : 1'b0;
    end

    // Monitor: pops the scoreboard on every line write
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (FIFO_dot_rvalid) last_rv = cyc;
            if (op_done) done_cnt++;
            if (FIFO_dot_re) begin
                re_cnt++;
                if (FIFO_dot_empty || (FIFO_output_almostfull && !cur_wtm)) re_viol++;
            end
            if (FIFO_output_we || MEM_result_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: fifo_we=%0b mem_we=%0b, required no write",
                             FIFO_output_we, MEM_result_we);
                end else begin
                    e = exp_q.pop_front();
                    if ({FIFO_output_we, MEM_result_we} != (e.is_mem ? 2'b01 : 2'b10)) begin
                        errors++;
                        $display("FAIL write_kind: fifo_we=%0b mem_we=%0b, required is_mem=%0b",
                                 FIFO_output_we, MEM_result_we, e.is_mem);
                    end
                    checks++;
                    if ((e.is_mem ? MEM_result_wdata : FIFO_output_wdata) != e.data) begin
                        errors++;
                        $display("FAIL line_data: got %h required %h",
                                 e.is_mem ? MEM_result_wdata : FIFO_output_wdata, e.data);
                    end
                    if (e.is_mem) begin
                        checks++;
                        if (MEM_result_waddr != e.addr) begin
                            errors++;
                            $display("FAIL waddr: got %h required %h", MEM_result_waddr, e.addr);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input int first, input int n, input int tail_base,
                                             input bit tail_zero);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) begin
            if (k < n)          l[32*k +: 32] = 32'(first + k);
            else if (tail_zero) l[32*k +: 32] = 32'd0;
            else                l[32*k +: 32] = 32'(tail_base + k);
        end
        return l;
    endfunction

    task automatic push_vals(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wp] = 32'(first + i);
            wp = wp + 8'd1;
        end
    endtask

    task automatic expect_wr(input bit is_mem, input logic [15:0] addr, input logic [511:0] data);
        wr_t e;
        e.is_mem = is_mem;
        e.addr   = addr;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    task automatic start_op(input int nv, input bit wtm, input logic [15:0] off);
        @(negedge clk);
        regs[3]  = {15'd0, wtm, 16'(nv)};
        regs[4]  = {16'd0, off};
        cur_wtm  = wtm;
        re_cnt   = 0;
        re_viol  = 0;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
    endtask

    // Called on the first negedge after op_start was sampled
    task automatic wait_done(input string name, input int exp_gap);
        int n = 0;
        while (!op_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!op_done) begin
            errors++;
            $display("FAIL %s_timeout: op_done not seen within 400 cycles", name);
        end else if (exp_gap >= 0) begin
            chk({name, "_done_gap"}, 64'(cyc - last_rv), 64'(exp_gap));
        end else begin
            chk({name, "_done_latency"}, 64'(n), 64'd0);
        end
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(op_done), 64'd0);
        chk({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk("reset_op_done", 64'(op_done), 64'd0);
        chk("reset_re", 64'(FIFO_dot_re), 64'd0);
        chk("reset_fifo_we", 64'(FIFO_output_we), 64'd0);
        chk("reset_mem_we", 64'(MEM_result_we), 64'd0);
        reset = 1'b0;

        // one full line to the output FIFO
        push_vals(1, 16);
        expect_wr(1'b0, 16'h0, mk_line(1, 16, 0, 1'b0));
        start_op(16, 1'b0, 16'h0);
        wait_done("t1", 2);

        // three lines to BRAM, last one partial
        push_vals(0, 40);
        expect_wr(1'b1, 16'h0010, mk_line(0, 16, 0, 1'b0));
        expect_wr(1'b1, 16'h0011, mk_line(16, 16, 0, 1'b0));
        expect_wr(1'b1, 16'h0012, mk_line(32, 8, 16, ZF));
        start_op(40, 1'b1, 16'h0010);
        wait_done("t2", 2);

        // empty op
        start_op(0, 1'b0, 16'h0);
        wait_done("t3", -1);
        chk("t3_re_count", 64'(re_cnt), 64'd0);

        // empty toggling plus almostfull back-pressure
        push_vals(100, 32);
        expect_wr(1'b0, 16'h0, mk_line(100, 16, 0, 1'b0));
        expect_wr(1'b0, 16'h0, mk_line(116, 16, 0, 1'b0));
        toggle_en = 1'b1;
        start_op(32, 1'b0, 16'h0);
        fork
            wait_done("t4", 2);
            begin
                repeat (6) @(negedge clk);
                FIFO_output_almostfull = 1'b1;
                repeat (20) @(negedge clk);
                FIFO_output_almostfull = 1'b0;
            end
        join
        toggle_en = 1'b0;
        chk("t4_re_violations", 64'(re_viol), 64'd0);
        chk("t4_re_count", 64'(re_cnt), 64'd32);

        // address wrap
        push_vals(200, 32);
        expect_wr(1'b1, 16'hFFFF, mk_line(200, 16, 0, 1'b0));
        expect_wr(1'b1, 16'h0000, mk_line(216, 16, 0, 1'b0));
        start_op(32, 1'b1, 16'hFFFF);
        wait_done("t5", 2);

        // reset mid-op, then a clean op
        push_vals(300, 32);
        start_op(32, 1'b0, 16'h0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_re_after_reset", 64'(FIFO_dot_re), 64'd0);
        chk("t6_we_after_reset", 64'({FIFO_output_we, MEM_result_we}), 64'd0);
        chk("t6_done_after_reset", 64'(op_done), 64'd0);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t6_no_writes", 64'(exp_q.size()), 64'd0);
        wp = rp;
        push_vals(400, 16);
        expect_wr(1'b0, 16'h0, mk_line(400, 16, 0, 1'b0));
        start_op(16, 1'b0, 16'h0);
        wait_done("t6b", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/glm_dot_pack.md
Name: glm_dot_pack

Overview:
- Consumer end of the scalar dot-product stream.
- Drains 32-bit results from the dot FIFO, packs 16 per 512-bit line (lane k = value k mod 16) and writes completed lines either to an output FIFO or to a BRAM region at a programmable offset.
- Sits after the dot stage in the GLM pipeline; its output feeds the gradient/loss stages or host writeback.

Parameters:
- VALUES_PER_LINE, 16, 32-bit lanes per 512-bit line.
- LOG2_VALUES_PER_LINE, 4, log2 of VALUES_PER_LINE; lane index width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- op_start  input  1  one-cycle start pulse; sampled only in IDLE.
- op_done  output  1  one-cycle completion pulse.
- regs  input  32x5  instruction registers:
  - regs[3][15:0] = num_values.
  - regs[3][16] = write_to_mem.
  - regs[4][15:0] = mem_store_offset.
- FIFO_dot  fifo_read  32-bit data  uses re (out), rvalid, rdata[31:0], empty (in).
- FIFO_output  fifo_write  512-bit data  uses we, wdata[511:0] (out), almostfull (in).
- MEM_result  bram_write  512-bit data  uses we, waddr[15:0], wdata[511:0] (out).

Behaviour:
- Reset values: op_done=0, FIFO_dot.re=0, FIFO_output.we=0, MEM_result.we=0, state=IDLE, all counters 0, line register 0.
- FIFO read protocol: re registered; rvalid/rdata valid exactly 1 cycle after re=1.
- IDLE, on op_start:
  - latch num_values, write_to_mem, mem_store_offset.
  - clear requested, received, lane, lines_written.
  - if num_values==0: op_done=1 next cycle, no writes, stay IDLE; else -> PACK.
- PACK, read issue:
  - re=1 when !FIFO_dot.empty && requested<num_values && (write_to_mem || !FIFO_output.almostfull); then requested++.
  - FIFO_output.almostfull guarantees >=2 free slots, so one in-flight line is always accepted.
- PACK, on rvalid:
  - rdata -> line[32*lane+31 : 32*lane]; lane++, received++.
  - if lane==15 or received==num_values-1: line complete; lane -> 0.
- Line write: cycle after completion, exactly one of FIFO_output.we / MEM_result.we = 1 (chosen by write_to_mem) with the complete line.
  - MEM_result.waddr = mem_store_offset + lines_written (16-bit, wraps mod 2^16); lines_written++.
- Final line: when the final line is written -> DONE.
- DONE: op_done=1 for one cycle -> IDLE. op_done is therefore 2 cycles after the last rvalid.
- Simultaneous events:
  - rvalid and re in the same cycle are independent.
  - Line write in the cycle a new lane-0 value arrives: the new value goes into the fresh line; the written data is the snapshot taken at completion, via a separate output register.
- Lines per op: ceil(num_values/16).
- Writes never exceed 1 per 16 rvalids, except the final partial line.
- op_start outside IDLE: ignored.
- Reset mid-op: next cycle IDLE, all re/we low, op_done low; no partial line written. In-flight FIFO data is discarded; flushing it is the system's responsibility.

Optional Feature:
- Macro GLM_DOT_PACK_ZEROFILL_EN.
- Defined: the line register clears to 0 when each line is written, so unused lanes of a final partial line read 0.
- Undefined: no clear; unused lanes of a partial line keep the previous line's values (0 if the op's first line is partial, since the register is cleared at op_start).

Test Plan:
- num_values=16, write_to_mem=0, FIFO_dot preloaded 1..16 -> exactly one FIFO_output write, lane k = k+1; op_done 2 cycles after 16th rvalid.
- num_values=40, write_to_mem=1, offset=0x0010, values 0..39 -> MEM writes at 0x10, 0x11, 0x12. The third line has lanes 0..7 = 32..39. Lanes 8..15: 0 with ZEROFILL_EN; 24..31 without.
- num_values=0 -> no re, no we; op_done exactly 1 cycle after op_start.
- FIFO_dot.empty toggling every other cycle and FIFO_output.almostfull held high for 20 cycles mid-op, num_values=32 -> no re while almostfull; data order preserved; exactly 2 lines; no lost or duplicate values.
- offset=0xFFFF, num_values=32, write_to_mem=1 -> waddr 0xFFFF then 0x0000.
- Reset asserted 5 cycles into a num_values=32 op -> re/we low next cycle, no op_done; a new op_start with num_values=16 then completes correctly.
